// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback path.
//   PREG_W / WORD_W : physical register index and data word widths
//   p_reg, word     : the corresponding scalar types
//   wb_req_t        : one writeback request (valid, destination, data)
//   wrap_inc        : modulo increment used by round-robin pointers
package wb_arbiter_pkg;

  localparam int unsigned PREG_W = 6;
  localparam int unsigned WORD_W = 32;

  typedef logic [PREG_W-1:0] p_reg;
  typedef logic [WORD_W-1:0] word;

  typedef struct packed {
    logic valid;
    p_reg addr;
    word  data;
  } wb_req_t;

  // (idx + 1) mod n, without a divider.
  function automatic int unsigned wrap_inc(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// Combinational round-robin selection for the writeback arbiter.
// Scans requesters starting at i_rr_ptr, granting up to NUM_WP of them. A requester whose
// destination matches an address already granted this cycle is skipped without using a port.
//   i_en        : grants allowed this cycle (not stalled, not in reset)
//   i_valid     : per-requester valid
//   i_addr      : per-requester destination register
//   i_rr_ptr    : scan start index
//   o_ready     : per-requester grant
//   o_port_vld  : write port j carries a grant
//   o_port_idx  : requester index feeding write port j
//   o_any       : at least one grant issued
//   o_last      : index of the last requester granted in scan order
module rr_pick
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned NUM_WP  = 2
) (
  input  logic                                         i_en,
  input  logic [NUM_REQ-1:0]                           i_valid,
  input  logic [NUM_REQ-1:0][PREG_W-1:0]               i_addr,
  input  logic [$clog2(NUM_REQ)-1:0]                   i_rr_ptr,
  output logic [NUM_REQ-1:0]                           o_ready,
  output logic [NUM_WP-1:0]                            o_port_vld,
  output logic [NUM_WP-1:0][$clog2(NUM_REQ)-1:0]       o_port_idx,
  output logic                                         o_any,
  output logic [$clog2(NUM_REQ)-1:0]                   o_last
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  // Addresses already claimed this cycle, one slot per write port.
  logic [NUM_WP-1:0][PREG_W-1:0] used_addr;

  always_comb begin
    int unsigned n;
    int unsigned k;
    logic        conflict;

    o_ready    = '0;
    o_port_vld = '0;
    o_port_idx = '0;
    o_any      = 1'b0;
    o_last     = '0;
    used_addr  = '0;
    n          = 0;
    k          = 0;
    conflict   = 1'b0;

    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = 32'(i_rr_ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;

      conflict = 1'b0;
      for (int unsigned j = 0; j < NUM_WP; j++) begin
        if (j < n && used_addr[j] == i_addr[k]) conflict = 1'b1;
      end

      if (i_en && i_valid[k] && n < NUM_WP && !conflict) begin
        o_ready[k]    = 1'b1;
        o_port_vld[n] = 1'b1;
        o_port_idx[n] = k[PTR_W-1:0];
        used_addr[n]  = i_addr[k];
        o_any         = 1'b1;
        o_last        = k[PTR_W-1:0];
        n             = n + 1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: routes up to NUM_WP of NUM_REQ functional-unit results per cycle onto
// the register file write ports, round-robin, avoiding duplicate destinations.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_stall        : suppress all grants this cycle
//   i_req_valid    : requester k holds a result
//   i_req_addr     : destination register per requester
//   i_req_data     : result data per requester
//   o_req_ready    : grant (combinational)
//   o_w_en         : registered write enable per port (never set for register 0)
//   o_w_addr       : registered write address per port (holds when not enabled)
//   o_w_data       : registered write data per port (holds when not enabled)
//   o_rr_ptr       : current round-robin start index
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned NUM_WP  = 2
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_stall,
  input  logic [NUM_REQ-1:0]                 i_req_valid,
  input  logic [NUM_REQ-1:0][PREG_W-1:0]     i_req_addr,
  input  logic [NUM_REQ-1:0][WORD_W-1:0]     i_req_data,
  output logic [NUM_REQ-1:0]                 o_req_ready,
  output logic [NUM_WP-1:0]                  o_w_en,
  output logic [NUM_WP-1:0][PREG_W-1:0]      o_w_addr,
  output logic [NUM_WP-1:0][WORD_W-1:0]      o_w_data,
  output logic [$clog2(NUM_REQ)-1:0]         o_rr_ptr
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]                  rr_ptr_q;
  logic [PTR_W-1:0]                  rr_ptr_d;
  logic [NUM_WP-1:0]                 w_en_q;
  logic [NUM_WP-1:0][PREG_W-1:0]     w_addr_q;
  logic [NUM_WP-1:0][WORD_W-1:0]     w_data_q;

  logic                              pick_en;
  logic [NUM_WP-1:0]                 port_vld;
  logic [NUM_WP-1:0][PTR_W-1:0]      port_idx;
  logic                              any_grant;
  logic [PTR_W-1:0]                  last_idx;
  wb_req_t [NUM_WP-1:0]              port_req;

  // Gating with reset keeps an in-flight request from being accepted while in reset.
  assign pick_en = ~i_stall & i_rst_n;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .NUM_WP (NUM_WP)
  ) u_rr_pick (
    .i_en      (pick_en),
    .i_valid   (i_req_valid),
    .i_addr    (i_req_addr),
    .i_rr_ptr  (rr_ptr_q),
    .o_ready   (o_req_ready),
    .o_port_vld(port_vld),
    .o_port_idx(port_idx),
    .o_any     (any_grant),
    .o_last    (last_idx)
  );

  // Per-port request view; valid folds in the register-0 write suppression.
  always_comb begin
    port_req = '0;
    for (int unsigned p = 0; p < NUM_WP; p++) begin
      port_req[p].addr  = i_req_addr[port_idx[p]];
      port_req[p].data  = i_req_data[port_idx[p]];
      port_req[p].valid = port_vld[p] && (i_req_addr[port_idx[p]] != '0);
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_grant) rr_ptr_d = PTR_W'(wrap_inc(32'(last_idx), NUM_REQ));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr_q <= '0;
      w_en_q   <= '0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int unsigned p = 0; p < NUM_WP; p++) begin
        w_en_q[p] <= port_req[p].valid;
        if (port_req[p].valid) begin
          w_addr_q[p] <= port_req[p].addr;
          w_data_q[p] <= port_req[p].data;
        end
      end
    end
  end

  assign o_w_en   = w_en_q;
  assign o_w_addr = w_addr_q;
  assign o_w_data = w_data_q;
  assign o_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int NWP  = 2;

  logic                            i_clk;
  logic                            i_rst_n;
  logic                            i_stall;
  logic [NREQ-1:0]                 i_req_valid;
  logic [NREQ-1:0][PREG_W-1:0]     i_req_addr;
  logic [NREQ-1:0][WORD_W-1:0]     i_req_data;
  logic [NREQ-1:0]                 o_req_ready;
  logic [NWP-1:0]                  o_w_en;
  logic [NWP-1:0][PREG_W-1:0]      o_w_addr;
  logic [NWP-1:0][WORD_W-1:0]      o_w_data;
  logic [1:0]                      o_rr_ptr;

  int total = 0;
  int bad   = 0;

  wb_arbiter #(
    .NUM_REQ(NREQ),
    .NUM_WP (NWP)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_stall    (i_stall),
    .i_req_valid(i_req_valid),
    .i_req_addr (i_req_addr),
    .i_req_data (i_req_data),
    .o_req_ready(o_req_ready),
    .o_w_en     (o_w_en),
    .o_w_addr   (o_w_addr),
    .o_w_data   (o_w_data),
    .o_rr_ptr   (o_rr_ptr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n     = 1'b0;
    i_stall     = 1'b0;
    i_req_valid = '0;
    i_req_addr  = '0;
    i_req_data  = '0;
    #2;
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    i_rst_n     = 1'b1;
    i_stall     = 1'b0;
    i_req_valid = 4'b1111;
    for (int k = 0; k < NREQ; k++) begin
      i_req_addr[k] = PREG_W'(k + 1);
      i_req_data[k] = 32'h1000 + k;
    end
    #1 i_rst_n = 1'b0;
    #1;
    total++;
    if (o_req_ready !== 4'b0000) begin
      bad++; $display("FAIL reset_ready got=%b want=0000", o_req_ready);
    end
    total++;
    if (o_w_en !== 2'b00 || o_w_addr !== '0 || o_w_data !== '0 || o_rr_ptr !== 2'd0) begin
      bad++;
      $display("FAIL reset_regs got en=%b addr=%h data=%h ptr=%0d want all zero",
               o_w_en, o_w_addr, o_w_data, o_rr_ptr);
    end
    tick();
    // Clock edge while still in reset: nothing may be accepted or written.
    total++;
    if (o_req_ready !== 4'b0000 || o_w_en !== 2'b00 || o_rr_ptr !== 2'd0) begin
      bad++;
      $display("FAIL reset_held got ready=%b en=%b ptr=%0d want 0", o_req_ready, o_w_en, o_rr_ptr);
    end
    i_req_valid = '0;
    @(negedge i_clk);
    #2 i_rst_n = 1'b1;
  endtask

  task automatic test_single();
    i_req_valid   = 4'b0001;
    i_req_addr[0] = 6'd5;
    i_req_data[0] = 32'hAAAA0001;
    #1;
    total++;
    if (o_req_ready !== 4'b0001) begin
      bad++; $display("FAIL single_ready got=%b want=0001", o_req_ready);
    end
    tick();
    i_req_valid = '0;
    total++;
    if (o_w_en !== 2'b01 || o_w_addr[0] !== 6'd5 || o_w_data[0] !== 32'hAAAA0001) begin
      bad++;
      $display("FAIL single_write got en=%b addr=%0d data=%h want en=01 addr=5 data=aaaa0001",
               o_w_en, o_w_addr[0], o_w_data[0]);
    end
    total++;
    if (o_rr_ptr !== 2'd1) begin
      bad++; $display("FAIL single_ptr got=%0d want=1", o_rr_ptr);
    end
    tick();
    total++;
    if (o_w_en !== 2'b00 || o_w_addr[0] !== 6'd5) begin
      bad++; $display("FAIL single_one_cycle got en=%b addr=%0d want en=00 addr=5",
                      o_w_en, o_w_addr[0]);
    end
  endtask

  task automatic test_all_four();
    do_reset();
    i_req_valid = 4'b1111;
    for (int k = 0; k < NREQ; k++) begin
      i_req_addr[k] = PREG_W'(k + 1);
      i_req_data[k] = 32'hB000 + k;
    end
    #1;
    total++;
    if (o_req_ready !== 4'b0011) begin
      bad++; $display("FAIL all4_c0_ready got=%b want=0011", o_req_ready);
    end
    tick();
    i_req_valid = 4'b1100;
    total++;
    if (o_w_en !== 2'b11 || o_w_addr[0] !== 6'd1 || o_w_addr[1] !== 6'd2 ||
        o_w_data[1] !== 32'hB001 || o_rr_ptr !== 2'd2) begin
      bad++;
      $display("FAIL all4_c0_write got en=%b a0=%0d a1=%0d d1=%h ptr=%0d want 11 1 2 b001 2",
               o_w_en, o_w_addr[0], o_w_addr[1], o_w_data[1], o_rr_ptr);
    end
    #1;
    total++;
    if (o_req_ready !== 4'b1100) begin
      bad++; $display("FAIL all4_c1_ready got=%b want=1100", o_req_ready);
    end
    tick();
    i_req_valid = '0;
    total++;
    if (o_w_en !== 2'b11 || o_w_addr[0] !== 6'd3 || o_w_addr[1] !== 6'd4 ||
        o_rr_ptr !== 2'd0) begin
      bad++;
      $display("FAIL all4_c1_write got en=%b a0=%0d a1=%0d ptr=%0d want 11 3 4 0",
               o_w_en, o_w_addr[0], o_w_addr[1], o_rr_ptr);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    i_req_valid   = 4'b0111;
    i_req_addr[0] = 6'd7;
    i_req_addr[1] = 6'd7;
    i_req_addr[2] = 6'd9;
    i_req_data[0] = 32'hC0;
    i_req_data[1] = 32'hC1;
    i_req_data[2] = 32'hC2;
    #1;
    total++;
    if (o_req_ready !== 4'b0101) begin
      bad++; $display("FAIL conflict_ready got=%b want=0101", o_req_ready);
    end
    tick();
    i_req_valid = 4'b0010;
    total++;
    if (o_w_en !== 2'b11 || o_w_addr[0] !== 6'd7 || o_w_addr[1] !== 6'd9 ||
        o_w_data[1] !== 32'hC2 || o_rr_ptr !== 2'd3) begin
      bad++;
      $display("FAIL conflict_write got en=%b a0=%0d a1=%0d d1=%h ptr=%0d want 11 7 9 c2 3",
               o_w_en, o_w_addr[0], o_w_addr[1], o_w_data[1], o_rr_ptr);
    end
    #1;
    total++;
    if (o_req_ready !== 4'b0010) begin
      bad++; $display("FAIL conflict_retry_ready got=%b want=0010", o_req_ready);
    end
    tick();
    i_req_valid = '0;
    total++;
    if (o_w_en !== 2'b01 || o_w_addr[0] !== 6'd7 || o_w_data[0] !== 32'hC1 ||
        o_rr_ptr !== 2'd2) begin
      bad++;
      $display("FAIL conflict_retry_write got en=%b a0=%0d d0=%h ptr=%0d want 01 7 c1 2",
               o_w_en, o_w_addr[0], o_w_data[0], o_rr_ptr);
    end
  endtask

  task automatic test_zero_addr();
    do_reset();
    i_req_valid   = 4'b1000;
    i_req_addr[3] = 6'd0;
    i_req_data[3] = 32'hDEAD;
    #1;
    total++;
    if (o_req_ready !== 4'b1000) begin
      bad++; $display("FAIL zero_ready got=%b want=1000", o_req_ready);
    end
    tick();
    i_req_valid = '0;
    total++;
    if (o_w_en !== 2'b00 || o_rr_ptr !== 2'd0 || o_w_data[0] !== 32'h0) begin
      bad++;
      $display("FAIL zero_write got en=%b ptr=%0d d0=%h want en=00 ptr=0 d0=0",
               o_w_en, o_rr_ptr, o_w_data[0]);
    end
  endtask

  task automatic test_stall();
    do_reset();
    i_req_valid = 4'b1111;
    for (int k = 0; k < NREQ; k++) i_req_addr[k] = PREG_W'(k + 10);
    i_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (o_req_ready !== 4'b0000) begin
        bad++; $display("FAIL stall_ready cyc=%0d got=%b want=0000", c, o_req_ready);
      end
      tick();
      total++;
      if (o_w_en !== 2'b00 || o_rr_ptr !== 2'd0) begin
        bad++; $display("FAIL stall_hold cyc=%0d got en=%b ptr=%0d want 00 0", c, o_w_en, o_rr_ptr);
      end
    end
    i_stall = 1'b0;
    #1;
    total++;
    if (o_req_ready !== 4'b0011) begin
      bad++; $display("FAIL stall_resume got=%b want=0011", o_req_ready);
    end
    tick();
    i_req_valid = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    i_req_valid   = 4'b0001;
    i_req_addr[0] = 6'd12;
    i_req_data[0] = 32'h5555;
    tick();
    i_req_valid = '0;
    total++;
    if (o_w_en !== 2'b01) begin
      bad++; $display("FAIL areset_pre got en=%b want=01", o_w_en);
    end
    #2 i_rst_n = 1'b0;
    #1;
    total++;
    if (o_w_en !== 2'b00 || o_w_addr !== '0 || o_w_data !== '0 || o_rr_ptr !== 2'd0) begin
      bad++;
      $display("FAIL areset_clear got en=%b addr=%h data=%h ptr=%0d want zero",
               o_w_en, o_w_addr, o_w_data, o_rr_ptr);
    end
    #1 i_rst_n = 1'b1;
  endtask

  task automatic test_fairness();
    int wait_cnt [NREQ];
    do_reset();
    i_req_valid = 4'b1111;
    for (int k = 0; k < NREQ; k++) begin
      i_req_addr[k] = PREG_W'(20 + k);
      wait_cnt[k]   = 0;
    end
    for (int c = 0; c < 8; c++) begin
      #1;
      for (int k = 0; k < NREQ; k++) begin
        if (o_req_ready[k]) wait_cnt[k] = 0;
        else wait_cnt[k]++;
        total++;
        if (wait_cnt[k] >= 2) begin
          bad++; $display("FAIL fairness req=%0d cyc=%0d waited=%0d want<2", k, c, wait_cnt[k]);
        end
      end
      tick();
    end
    i_req_valid = '0;
  endtask

  task automatic test_random();
    int          m_ptr;
    logic [1:0]  m_en;
    p_reg        m_addr [NWP];
    word         m_data [NWP];
    int          order [$];
    p_reg        used [$];
    logic [3:0]  exp_ready;
    logic        hit;
    int          k;
    p_reg        s_addr [NREQ];
    word         s_data [NREQ];

    do_reset();
    m_ptr = 0;
    m_en  = '0;
    for (int p = 0; p < NWP; p++) begin
      m_addr[p] = '0;
      m_data[p] = '0;
    end
    for (int cyc = 0; cyc < 300; cyc++) begin
      i_stall     = ($urandom_range(0, 7) == 0);
      i_req_valid = 4'($urandom_range(0, 15));
      for (int r = 0; r < NREQ; r++) begin
        s_addr[r]     = PREG_W'($urandom_range(0, 5));
        s_data[r]     = $urandom;
        i_req_addr[r] = s_addr[r];
        i_req_data[r] = s_data[r];
      end

      exp_ready = '0;
      order.delete();
      used.delete();
      if (!i_stall) begin
        for (int i = 0; i < NREQ; i++) begin
          k = (m_ptr + i) % NREQ;
          if (i_req_valid[k] && order.size() < NWP) begin
            hit = 1'b0;
            foreach (used[u]) if (used[u] == s_addr[k]) hit = 1'b1;
            if (!hit) begin
              exp_ready[k] = 1'b1;
              order.push_back(k);
              used.push_back(s_addr[k]);
            end
          end
        end
      end

      #1;
      total++;
      if (o_req_ready !== exp_ready) begin
        bad++;
        $display("FAIL rand_ready cyc=%0d got=%b want=%b ptr=%0d", cyc, o_req_ready, exp_ready,
                 m_ptr);
      end
      tick();

      if (order.size() > 0) m_ptr = (order[order.size()-1] + 1) % NREQ;
      for (int p = 0; p < NWP; p++) begin
        m_en[p] = 1'b0;
        if (p < order.size() && s_addr[order[p]] != 0) begin
          m_en[p]   = 1'b1;
          m_addr[p] = s_addr[order[p]];
          m_data[p] = s_data[order[p]];
        end
      end

      total++;
      if (o_w_en !== m_en || o_rr_ptr !== 2'(m_ptr)) begin
        bad++;
        $display("FAIL rand_en cyc=%0d got en=%b ptr=%0d want en=%b ptr=%0d",
                 cyc, o_w_en, o_rr_ptr, m_en, m_ptr);
      end
      for (int p = 0; p < NWP; p++) begin
        total++;
        if (o_w_addr[p] !== m_addr[p] || o_w_data[p] !== m_data[p]) begin
          bad++;
          $display("FAIL rand_port cyc=%0d port=%0d got a=%0d d=%h want a=%0d d=%h",
                   cyc, p, o_w_addr[p], o_w_data[p], m_addr[p], m_data[p]);
        end
      end
      total++;
      if (o_w_en === 2'b11 && o_w_addr[0] === o_w_addr[1]) begin
        bad++;
        $display("FAIL rand_dup cyc=%0d got a0=%0d a1=%0d want distinct",
                 cyc, o_w_addr[0], o_w_addr[1]);
      end
    end
    i_req_valid = '0;
    i_stall     = 1'b0;
  endtask

  initial begin
    i_rst_n     = 1'b1;
    i_stall     = 1'b0;
    i_req_valid = '0;
    i_req_addr  = '0;
    i_req_data  = '0;
    test_reset();
    test_single();
    test_all_four();
    test_conflict();
    test_zero_addr();
    test_stall();
    test_async_reset();
    test_fairness();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
